mem_refill_arbiter: RTL and testbench

- Shares the single memory refill port between two cache controllers (cc0 = instruction-side cache4way, cc1 = data-side cache4way).
- Grants one 4-word line refill burst at a time with round-robin fairness.
- Sequences the per-word memory addresses and steers ack/data/word index back to the granted cache.
- Sits between the caches' *_cc2mem/*_mem2cc ports and the memory model/bus; includes a per-beat timeout watchdog.

---
 rtl/cache_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 18 +
 rtl/mem_refill_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_refill_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache refill path.
package cache_pkg;

  // Refill arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  localparam int unsigned WORD_OFFSET_DFLT = 2;
  localparam int unsigned WORDS_PER_LINE   = 1 << WORD_OFFSET_DFLT;
  localparam int unsigned BYTE_OFFSET      = 2;

  // Requester ids, also the bit positions in grant vectors
  localparam int unsigned CC0 = 0;
  localparam int unsigned CC1 = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one
// that was not served last.
module rr_arbiter2
  import cache_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       rr_last_i,  // 1: cc1 was served last
  output logic [1:0] gnt_o_c
);

  // One-hot grant from request vector and last-served id
  always_comb begin
    gnt_o_c      = '0;
    gnt_o_c[CC0] = req_i[CC0] & (~req_i[CC1] | rr_last_i);
    gnt_o_c[CC1] = req_i[CC1] & (~req_i[CC0] | ~rr_last_i);
  end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Shares the single memory refill port between the instruction-side (cc0)
// and data-side (cc1) caches, one 4-word line burst at a time.
module mem_refill_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned ADR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WORD_OFFSET = 2,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   req_cc02arb,
  input  logic [ADR_WIDTH-1:0]   adr_cc02arb,
  output logic                   ack_arb2cc0,
  output logic [DATA_WIDTH-1:0]  dat_arb2cc0,
  output logic [WORD_OFFSET-1:0] word_arb2cc0,

  input  logic                   req_cc12arb,
  input  logic [ADR_WIDTH-1:0]   adr_cc12arb,
  output logic                   ack_arb2cc1,
  output logic [DATA_WIDTH-1:0]  dat_arb2cc1,
  output logic [WORD_OFFSET-1:0] word_arb2cc1,

  output logic                   req_arb2mem,
  output logic [ADR_WIDTH-1:0]   adr_arb2mem,
  input  logic                   ack_mem2arb,
  input  logic [DATA_WIDTH-1:0]  dat_mem2arb,

  output logic [1:0]             gnt_arb,
  output logic                   err_arb
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  localparam logic [WORD_OFFSET-1:0] LAST_BEAT = WORD_OFFSET'((1 << WORD_OFFSET) - 1);
  localparam logic [WORD_OFFSET-1:0] BEAT_ONE  = WORD_OFFSET'(1);
  localparam logic [ADR_WIDTH-1:0]   LINE_MASK =
    ~ADR_WIDTH'((1 << (WORD_OFFSET + BYTE_OFFSET)) - 1);
  localparam logic [ADR_WIDTH-1:0]   BEAT_STEP = ADR_WIDTH'(1 << BYTE_OFFSET);
  localparam logic [WD_W-1:0]        WD_LIMIT  = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]        WD_ONE    = WD_W'(1);

  arb_state_e             state_q, state_d;
  logic [1:0]             gnt_q, gnt_d;
  logic                   req_q, req_d;
  logic [ADR_WIDTH-1:0]   adr_q, adr_d;
  logic [WORD_OFFSET-1:0] beat_q, beat_d;
  logic [WD_W-1:0]        wdog_q, wdog_d;
  logic                   rr_last_q, rr_last_d;
  logic                   err_q, err_d;

  logic [1:0]             pick_c;
  logic [ADR_WIDTH-1:0]   sel_adr_c;
  logic                   in_burst_c;

  rr_arbiter2 u_rr (
    .req_i     ({req_cc12arb, req_cc02arb}),
    .rr_last_i (rr_last_q),
    .gnt_o_c   (pick_c)
  );

  assign sel_adr_c  = pick_c[CC1] ? adr_cc12arb : adr_cc02arb;
  assign in_burst_c = (state_q == BURST);

  // State and output registers; reset abandons any burst in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      req_q     <= 1'b0;
      adr_q     <= '0;
      beat_q    <= '0;
      wdog_q    <= '0;
      rr_last_q <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      req_q     <= req_d;
      adr_q     <= adr_d;
      beat_q    <= beat_d;
      wdog_q    <= wdog_d;
      rr_last_q <= rr_last_d;
      err_q     <= err_d;
    end
  end

  // Grant, beat sequencing, watchdog and end-of-burst handling
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    req_d     = req_q;
    adr_d     = adr_q;
    beat_d    = beat_q;
    wdog_d    = wdog_q;
    rr_last_d = rr_last_q;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|pick_c) begin
          state_d = BURST;
          gnt_d   = pick_c;
          req_d   = 1'b1;
          adr_d   = sel_adr_c & LINE_MASK;
          beat_d  = '0;
          wdog_d  = '0;
        end
      end

      BURST: begin
        if (ack_mem2arb) begin
          wdog_d = '0;
          if (beat_q == LAST_BEAT) begin
            state_d   = GAP;
            req_d     = 1'b0;
            adr_d     = '0;
            rr_last_d = gnt_q[CC1];
          end else begin
            beat_d = beat_q + BEAT_ONE;
            adr_d  = adr_q + BEAT_STEP;
          end
        end else if (wdog_q == WD_LIMIT) begin
          // Memory stalled too long: drop the burst and free the port
          state_d   = GAP;
          req_d     = 1'b0;
          adr_d     = '0;
          wdog_d    = '0;
          err_d     = 1'b1;
          rr_last_d = gnt_q[CC1];
        end else begin
          wdog_d = wdog_q + WD_ONE;
        end
      end

      GAP: begin
        state_d = IDLE;
        gnt_d   = '0;
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        req_d   = 1'b0;
        adr_d   = '0;
      end
    endcase
  end

  assign gnt_arb     = gnt_q;
  assign req_arb2mem = req_q;
  assign adr_arb2mem = adr_q;
  assign err_arb     = err_q;

  // Zero-latency steering back to the granted cache; a dropped request mutes acks
  assign ack_arb2cc0  = ack_mem2arb & gnt_q[CC0] & in_burst_c & req_cc02arb;
  assign ack_arb2cc1  = ack_mem2arb & gnt_q[CC1] & in_burst_c & req_cc12arb;
  assign dat_arb2cc0  = dat_mem2arb;
  assign dat_arb2cc1  = dat_mem2arb;
  assign word_arb2cc0 = beat_q;
  assign word_arb2cc1 = beat_q;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed bench for mem_refill_arbiter with a beat scoreboard.
module tb_mem_refill_arbiter;

  logic        clk;
  logic        rst;
  logic        req_cc02arb, req_cc12arb;
  logic [31:0] adr_cc02arb, adr_cc12arb;
  logic        ack_arb2cc0, ack_arb2cc1;
  logic [31:0] dat_arb2cc0, dat_arb2cc1;
  logic [1:0]  word_arb2cc0, word_arb2cc1;
  logic        req_arb2mem;
  logic [31:0] adr_arb2mem;
  logic        ack_mem2arb;
  logic [31:0] dat_mem2arb;
  logic [1:0]  gnt_arb;
  logic        err_arb;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] adr;
    logic [1:0]  word;
    logic        vis;
  } exp_t;

  exp_t sb[$];

  mem_refill_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_cc02arb  (req_cc02arb),
    .adr_cc02arb  (adr_cc02arb),
    .ack_arb2cc0  (ack_arb2cc0),
    .dat_arb2cc0  (dat_arb2cc0),
    .word_arb2cc0 (word_arb2cc0),
    .req_cc12arb  (req_cc12arb),
    .adr_cc12arb  (adr_cc12arb),
    .ack_arb2cc1  (ack_arb2cc1),
    .dat_arb2cc1  (dat_arb2cc1),
    .word_arb2cc1 (word_arb2cc1),
    .req_arb2mem  (req_arb2mem),
    .adr_arb2mem  (adr_arb2mem),
    .ack_mem2arb  (ack_mem2arb),
    .dat_mem2arb  (dat_mem2arb),
    .gnt_arb      (gnt_arb),
    .err_arb      (err_arb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation did not finish");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"},   64'(gnt_arb), 64'd0);
    chk({tag, "_req"},   64'(req_arb2mem), 64'd0);
    chk({tag, "_adr"},   64'(adr_arb2mem), 64'd0);
    chk({tag, "_err"},   64'(err_arb), 64'd0);
    chk({tag, "_ack0"},  64'(ack_arb2cc0), 64'd0);
    chk({tag, "_ack1"},  64'(ack_arb2cc1), 64'd0);
    chk({tag, "_word0"}, 64'(word_arb2cc0), 64'd0);
    chk({tag, "_word1"}, 64'(word_arb2cc1), 64'd0);
  endtask

  function automatic logic ack_of(input int id);
    return (id == 1) ? ack_arb2cc1 : ack_arb2cc0;
  endfunction

  function automatic logic ack_other(input int id);
    return (id == 1) ? ack_arb2cc0 : ack_arb2cc1;
  endfunction

  // Waits for the burst of requester id, feeds 4 acks, checks every beat
  // against the scoreboard, then checks the GAP cycle.
  task automatic do_burst(input int id, input logic [31:0] base, input int drop_after,
                          input logic keep_req, input logic fixed_dat, output int waited);
    exp_t        e;
    logic [31:0] d;
    logic [31:0] orig_adr;
    logic [1:0]  g;
    int          n;
    n = 0;
    g = (id == 1) ? 2'b10 : 2'b01;
    while (!req_arb2mem && n < 16) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    chk("burst_start", 64'(req_arb2mem), 64'd1);
    chk("burst_grant", 64'(gnt_arb), 64'(g));
    for (int k = 0; k < 4; k++) begin
      e.adr  = base + 32'(4 * k);
      e.word = 2'(k);
      e.vis  = (k < drop_after);
      sb.push_back(e);
    end
    orig_adr = (id == 1) ? adr_cc12arb : adr_cc02arb;
    for (int k = 0; k < 4; k++) begin
      if (k == drop_after) begin
        if (id == 1) req_cc12arb = 1'b0; else req_cc02arb = 1'b0;
      end
      if (k == 1) begin
        if (id == 1) adr_cc12arb = ~orig_adr; else adr_cc02arb = ~orig_adr;
      end
      e = sb.pop_front();
      chk("beat_mem_req", 64'(req_arb2mem), 64'd1);
      chk("beat_mem_adr", 64'(adr_arb2mem), 64'(e.adr));
      d = fixed_dat ? 32'hFFFF_FFFF : 32'($urandom());
      ack_mem2arb = 1'b1;
      dat_mem2arb = d;
      #1;
      chk("beat_ack", 64'(ack_of(id)), 64'(e.vis));
      chk("beat_ack_other", 64'(ack_other(id)), 64'd0);
      chk("beat_word", 64'((id == 1) ? word_arb2cc1 : word_arb2cc0), 64'(e.word));
      if (e.vis) chk("beat_dat", 64'((id == 1) ? dat_arb2cc1 : dat_arb2cc0), 64'(d));
      @(negedge clk);
    end
    ack_mem2arb = 1'b0;
    if (id == 1) adr_cc12arb = orig_adr; else adr_cc02arb = orig_adr;
    if (!keep_req) begin
      if (id == 1) req_cc12arb = 1'b0; else req_cc02arb = 1'b0;
    end
    chk("gap_req", 64'(req_arb2mem), 64'd0);
    chk("gap_gnt", 64'(gnt_arb), 64'(g));
    ack_mem2arb = 1'b1;
    #1;
    chk("gap_ack_ignored", 64'(ack_of(id)), 64'd0);
    #1;
    ack_mem2arb = 1'b0;
  endtask

  initial begin
    int n;
    int hi;
    rst = 1'b0;
    req_cc02arb = 1'b0; adr_cc02arb = '0;
    req_cc12arb = 1'b0; adr_cc12arb = '0;
    ack_mem2arb = 1'b0; dat_mem2arb = '0;

    // Reset state
    @(negedge clk);
    chk_quiet("reset");
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("idle");

    // cc0 alone, 1-cycle grant-to-memory latency, all-ones data
    req_cc02arb = 1'b1;
    adr_cc02arb = 32'hFF07_BD08;
    #1;
    chk("t1_pre_grant", 64'(gnt_arb), 64'd0);
    do_burst(0, 32'hFF07_BD00, 4, 1'b0, 1'b1, n);
    chk("t1_latency", 64'(n), 64'd1);
    @(negedge clk);
    chk("t1_idle_gnt", 64'(gnt_arb), 64'd0);

    // Fresh reset, then simultaneous requests: cc0 first, then cc1
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    req_cc02arb = 1'b1; adr_cc02arb = 32'h1234_5678;
    req_cc12arb = 1'b1; adr_cc12arb = 32'hA555_2D08;
    do_burst(0, 32'h1234_5670, 4, 1'b0, 1'b0, n);
    do_burst(1, 32'hA555_2D00, 4, 1'b0, 1'b0, n);
    // n counts the IDLE cycle plus the GAP cycle already seen low
    chk("t2_gap_ge2", 64'(n >= 2), 64'd1);

    // Fairness with both held: cc0, cc1, cc0
    req_cc02arb = 1'b1; req_cc12arb = 1'b1;
    do_burst(0, 32'h1234_5670, 4, 1'b1, 1'b0, n);
    do_burst(1, 32'hA555_2D00, 4, 1'b1, 1'b0, n);
    do_burst(0, 32'h1234_5670, 4, 1'b0, 1'b0, n);
    req_cc12arb = 1'b0;
    @(negedge clk);
    chk("t3_idle_gnt", 64'(gnt_arb), 64'd0);

    // Timeout on cc1 with cc0 pending
    req_cc12arb = 1'b1; adr_cc12arb = 32'h0BAD_F00C;
    n = 0;
    while (!req_arb2mem && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("t4_gnt_cc1", 64'(gnt_arb), 64'd2);
    req_cc02arb = 1'b1; adr_cc02arb = 32'h00C0_FFEE;
    hi = 0;
    while (req_arb2mem && hi < 200) begin
      hi++;
      @(negedge clk);
    end
    chk("t4_burst_cycles", 64'(hi), 64'd64);
    chk("t4_err_pulse", 64'(err_arb), 64'd1);
    chk("t4_req_low", 64'(req_arb2mem), 64'd0);
    chk("t4_gap_gnt", 64'(gnt_arb), 64'd2);
    @(negedge clk);
    chk("t4_err_width", 64'(err_arb), 64'd0);
    chk("t4_idle_gnt", 64'(gnt_arb), 64'd0);
    @(negedge clk);
    chk("t4_cc0_next", 64'(gnt_arb), 64'd1);
    req_cc12arb = 1'b0;
    do_burst(0, 32'h00C0_FFE0, 4, 1'b0, 1'b0, n);
    chk("t4_cc0_wait", 64'(n), 64'd0);
    @(negedge clk);

    // cc0 drops its request after 2 acks; beats 3-4 still go to memory
    req_cc02arb = 1'b1; adr_cc02arb = 32'h4000_0014;
    do_burst(0, 32'h4000_0010, 2, 1'b0, 1'b0, n);
    @(negedge clk);

    // Reset in the middle of a cc1 burst
    req_cc12arb = 1'b1; adr_cc12arb = 32'h0000_1234;
    n = 0;
    while (!req_arb2mem && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("t6_mid_adr0", 64'(adr_arb2mem), 64'h1230);
    ack_mem2arb = 1'b1; dat_mem2arb = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t6_mid_adr1", 64'(adr_arb2mem), 64'h1234);
    rst = 1'b0;
    #1;
    chk_quiet("t6_async");
    @(negedge clk);
    ack_mem2arb = 1'b0;
    rst = 1'b1;
    sb.delete();
    do_burst(1, 32'h0000_1230, 4, 1'b0, 1'b0, n);
    chk("t6_restart_latency", 64'(n), 64'd1);
    @(negedge clk);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
